// File: rtl/ccd_frame_packer_if.sv
// Pixel capture and USB byte-stream signals of the CCD frame packer.
// master = capture/USB side (source of pixels, sink of bytes); slave = packer.
interface ccd_frame_packer_if #(
    parameter int PIX_W = 12
);
    logic             frame_start;
    logic             frame_end;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             ovf_clr;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             overflow;
    logic             busy;

    modport master (
        output frame_start, frame_end, pix_valid, pix_data, ovf_clr, tx_ready,
        input  tx_data, tx_valid, overflow, busy
    );

    modport slave (
        input  frame_start, frame_end, pix_valid, pix_data, ovf_clr, tx_ready,
        output tx_data, tx_valid, overflow, busy
    );
endinterface

// File: rtl/ccd_frame_packer.sv
// Buffers one CCD line in a FIFO and re-emits it as a framed byte stream:
// A5 5A FN_H FN_L {PX_H PX_L}* CN_H CN_L CHK, with USB back-pressure absorbed.
module ccd_frame_packer #(
    parameter int PIX_W   = 12,
    parameter int FIFO_AW = 13
) (
    input logic              clk,
    input logic              rst,
    ccd_frame_packer_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] data;
    } entry_t;

    typedef enum logic [3:0] {
        S_IDLE, S_H0, S_H1, S_FNH, S_FNL, S_FETCH, S_LOAD,
        S_PXH, S_PXL, S_CNH, S_CNL, S_CHK
    } state_t;

    entry_t             mem [DEPTH];
    entry_t             rd_q;
    entry_t             wr_entry;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               wr_en, rd_en, pix_drop, fifo_empty;
    logic               in_frame, marker_pend, ovf_q;

    state_t             state, state_nxt;
    logic [PIX_W-1:0]   pix_q;
    logic [15:0]        frame_no, pix_cnt;
    logic [7:0]         chk, tx_byte;
    logic               tx_vld, xfer;

    assign fifo_empty = (count == '0);

    // One write port: a deferred marker owns the slot in the cycle after FRAME_END.
    // Pixels stop one short of full so the end marker always fits.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '0;
        pix_drop = 1'b0;
        if (marker_pend) begin
            wr_en         = 1'b1;
            wr_entry.last = 1'b1;
        end else if (in_frame && bus.pix_valid) begin
            if (count < (FIFO_AW+1)'(DEPTH - 1)) begin
                wr_en         = 1'b1;
                wr_entry.data = bus.pix_data;
            end else begin
                pix_drop = 1'b1;
            end
        end else if (in_frame && bus.frame_end) begin
            wr_en         = 1'b1;
            wr_entry.last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame    <= 1'b0;
            marker_pend <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            marker_pend <= in_frame && bus.frame_end && bus.pix_valid;
            if (!in_frame && bus.frame_start)
                in_frame <= 1'b1;
            else if (in_frame && bus.frame_end)
                in_frame <= 1'b0;
            if (pix_drop)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
        if (rd_en) rd_q <= mem[rd_ptr];
    end

    assign xfer = tx_vld && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // The next FIFO read is launched on the accepting edge of the previous low
    // byte, so a pixel costs PX_H, PX_L and one LOAD cycle with TX_READY high.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        tx_vld    = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_H0;
            S_H0:    begin tx_vld = 1'b1; tx_byte = 8'hA5;          if (bus.tx_ready) state_nxt = S_H1;  end
            S_H1:    begin tx_vld = 1'b1; tx_byte = 8'h5A;          if (bus.tx_ready) state_nxt = S_FNH; end
            S_FNH:   begin tx_vld = 1'b1; tx_byte = frame_no[15:8]; if (bus.tx_ready) state_nxt = S_FNL; end
            S_FNL, S_PXL: begin
                tx_vld  = 1'b1;
                tx_byte = (state == S_FNL) ? frame_no[7:0] : pix_q[7:0];
                if (bus.tx_ready) begin
                    if (!fifo_empty) begin
                        rd_en     = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: if (!fifo_empty) begin rd_en = 1'b1; state_nxt = S_LOAD; end
            S_LOAD:  state_nxt = rd_q.last ? S_CNH : S_PXH;
            S_PXH:   begin tx_vld = 1'b1; tx_byte = 8'(pix_q >> 8); if (bus.tx_ready) state_nxt = S_PXL; end
            S_CNH:   begin tx_vld = 1'b1; tx_byte = pix_cnt[15:8];  if (bus.tx_ready) state_nxt = S_CNL; end
            S_CNL:   begin tx_vld = 1'b1; tx_byte = pix_cnt[7:0];   if (bus.tx_ready) state_nxt = S_CHK; end
            S_CHK:   begin tx_vld = 1'b1; tx_byte = chk;            if (bus.tx_ready) state_nxt = S_IDLE; end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_no <= '0;
            pix_cnt  <= '0;
            chk      <= '0;
            pix_q    <= '0;
        end else begin
            if (state == S_IDLE) begin
                chk     <= '0;
                pix_cnt <= '0;
            end else if (xfer && state != S_CHK) begin
                chk <= chk ^ tx_byte;
            end
            if (state == S_LOAD && !rd_q.last) begin
                pix_q <= rd_q.data;
                if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
            end
            if (state == S_CHK && bus.tx_ready) frame_no <= frame_no + 16'd1;
        end
    end

    assign bus.tx_data  = tx_byte;
    assign bus.tx_valid = tx_vld;
    assign bus.overflow = ovf_q;
    assign bus.busy     = in_frame || !fifo_empty || (state != S_IDLE);
endmodule

// File: tb/tb_ccd_frame_packer.sv
// Scoreboard bench: stimulus pushes the expected byte stream, a monitor pops
// and compares every accepted byte and checks hold-stability under stalls.
module tb_ccd_frame_packer;
    localparam int PIX_W   = 12;
    localparam int FIFO_AW = 13;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccd_frame_packer_if #(.PIX_W(PIX_W)) bus ();
    ccd_frame_packer #(.PIX_W(PIX_W), .FIFO_AW(FIFO_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    bit         model_in_frame = 0;
    logic [15:0] model_fn = '0;
    logic [7:0] model_xor = '0;
    int         model_cnt = 0;
    int         room = 1 << 30;
    int         ready_mode = 1;
    bit         prev_stall = 0;
    int         prev_data = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(logic [7:0] b);
        exp_q.push_back(b);
        model_xor ^= b;
    endtask

    // Applies one cycle of input activity and updates the packet model from the rules.
    task automatic step(bit fs, bit fe, bit pv, logic [PIX_W-1:0] d);
        int c;
        bus.frame_start = fs;
        bus.frame_end   = fe;
        bus.pix_valid   = pv;
        bus.pix_data    = d;
        if (model_in_frame) begin
            if (pv && room > 0) begin
                room--;
                model_cnt++;
                push_exp(8'(d >> 8));
                push_exp(d[7:0]);
            end
            if (fe) begin
                c = (model_cnt > 65535) ? 65535 : model_cnt;
                push_exp(8'(c >> 8));
                push_exp(8'(c));
                exp_q.push_back(model_xor);
                model_fn++;
                model_in_frame = 0;
            end
        end else if (fs) begin
            model_in_frame = 1;
            model_xor = '0;
            model_cnt = 0;
            push_exp(8'hA5);
            push_exp(8'h5A);
            push_exp(model_fn[15:8]);
            push_exp(model_fn[7:0]);
        end
        @(posedge clk); #1;
        bus.frame_start = 0;
        bus.frame_end   = 0;
        bus.pix_valid   = 0;
        bus.pix_data    = '0;
        bus.ovf_clr     = 0;
    endtask

    task automatic wait_idle(int max, string name);
        int i = 0;
        while ((bus.busy || exp_q.size() != 0) && i < max) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, (bus.busy || exp_q.size() != 0) ? 1 : 0, 0);
    endtask

    initial begin
        bus.tx_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.tx_ready = 0;
                1:       bus.tx_ready = 1;
                default: bus.tx_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", int'(bus.tx_valid), 1);
                    check("hold_data", int'(bus.tx_data), prev_data);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", bus.tx_data, $time);
                    end else begin
                        check("tx_byte", int'(bus.tx_data), int'(exp_q.pop_front()));
                    end
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data  = int'(bus.tx_data);
            end
        end
    end

    initial begin
        bus.frame_start = 0;
        bus.frame_end   = 0;
        bus.pix_valid   = 0;
        bus.pix_data    = '0;
        bus.ovf_clr     = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_tx_valid", int'(bus.tx_valid), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;

        // Two-pixel frame 0, then an empty frame.
        ready_mode = 1;
        step(1, 0, 0, '0);
        step(0, 0, 1, 12'h123);
        step(0, 0, 1, 12'hABC);
        step(0, 1, 0, '0);
        wait_idle(200, "t1_drain");
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        wait_idle(200, "t2_drain");

        // Randomised frames with ignored-event corners and random back-pressure.
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            int np;
            bit end_with_pix;
            np = $urandom_range(0, 40);
            end_with_pix = f[0] && (np > 0);
            step(0, 0, 1, 12'($urandom_range(0, 4095)));
            step(0, 1, 0, '0);
            step(1, 0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
            for (int p = 0; p < np; p++) begin
                bit last;
                last = (p == np - 1) && end_with_pix;
                while ($urandom_range(0, 3) == 0) step(0, 0, 0, '0);
                step((p == 3) && !last, last, 1, 12'($urandom_range(0, 4095)));
            end
            if (!end_with_pix) step(0, 1, 0, '0);
            repeat ($urandom_range(0, 5)) step(0, 0, 0, '0);
        end
        wait_idle(8000, "rand_drain");
        check("rand_no_overflow", int'(bus.overflow), 0);

        // Pixel coinciding with FRAME_END.
        ready_mode = 1;
        step(1, 0, 0, '0);
        step(0, 0, 1, 12'h001);
        step(0, 0, 1, 12'hF0F);
        step(0, 1, 1, 12'h7E5);
        wait_idle(200, "t5_drain");

        // Long line with a 5000-cycle USB stall.
        ready_mode = 0;
        step(1, 0, 0, '0);
        for (int i = 0; i < 5340; i++) begin
            if (i == 5000) ready_mode = 1;
            step(0, 0, 1, 12'($urandom_range(0, 4095)));
        end
        step(0, 1, 0, '0);
        check("t3_no_overflow", int'(bus.overflow), 0);
        wait_idle(30000, "t3_drain");

        // Overfill with no draining: DEPTH-1 pixels kept, marker still delivered.
        ready_mode = 0;
        room = DEPTH - 1;
        step(1, 0, 0, '0);
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (i == DEPTH + 7) bus.ovf_clr = 1;
            step(0, 0, 1, 12'($urandom_range(0, 4095)));
        end
        check("ovf_set_wins", int'(bus.overflow), 1);
        step(0, 1, 0, '0);
        check("ovf_sticky", int'(bus.overflow), 1);
        bus.ovf_clr = 1;
        step(0, 0, 0, '0);
        check("ovf_cleared", int'(bus.overflow), 0);
        room = 1 << 30;
        ready_mode = 1;
        wait_idle(40000, "ovf_drain");

        // Reset in the middle of a pixel stream abandons the packet.
        step(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 12'($urandom_range(0, 4095)));
        rst = 1;
        exp_q.delete();
        model_in_frame = 0;
        model_fn = '0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("midrst_tx_valid", int'(bus.tx_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        step(1, 0, 0, '0);
        step(0, 0, 1, 12'h456);
        step(0, 1, 0, '0);
        wait_idle(200, "post_rst_drain");
        check("final_overflow", int'(bus.overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
